// File: rtl/bg7_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : bg7_fetch
//  Purpose  : Mode 7 BG1 coordinate sum, screen-over handling, tilemap and
//             character fetch, one 8bpp pixel committed per dot.
//  Config   : BG7_EXTBG_EN selects EXTBG output (7-bit colour + priority bit)
//  Revision : 1.0  initial release
// ============================================================================
module bg7_fetch #(
    parameter int VRAM_AW   = 15,
    parameter int TRANSP_IX = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      dot_en,
    input  logic [2:0]                dot_ctr,
    input  logic                      active,
    input  logic [3:0]                m7sel,
    input  logic signed [27:0]        prod_ax,
    input  logic signed [27:0]        prod_by,
    input  logic signed [27:0]        prod_cx,
    input  logic signed [27:0]        prod_dy,
    input  logic signed [12:0]        m7_xorig,
    input  logic signed [12:0]        m7_yorig,
    output logic [VRAM_AW-1:0]        vram_l_addr,
    output logic [VRAM_AW-1:0]        vram_h_addr,
    input  logic [7:0]                vram_rdata_l,
    input  logic [7:0]                vram_rdata_h,
    output logic [7:0]                pixel_color,
    output logic                      pixel_opaque,
    output logic                      pixel_prio,
    output logic                      fetch_busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAP  = 2'd1,
        S_CHR  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [7:0] C_TRANSP = 8'(TRANSP_IX);

    state_t               state_q, state_d;
    logic [9:0]           vx_q, vx_d, vy_q, vy_d;
    logic                 oob_q, oob_d;
    logic [1:0]           over_q, over_d;
    logic [VRAM_AW-1:0]   l_addr_q, l_addr_d, h_addr_q, h_addr_d;
    logic [7:0]           stg_color_q, stg_color_d;
    logic                 stg_opaque_q, stg_opaque_d;
    logic                 stg_prio_q, stg_prio_d;
    logic [7:0]           pix_color_q, pix_color_d;
    logic                 pix_opaque_q, pix_opaque_d;
    logic                 pix_prio_q, pix_prio_d;

    logic signed [28:0]   w_sx, w_sy;
    logic [20:0]          w_vx, w_vy;
    logic                 w_oob;
    logic [7:0]           w_tile;
    logic                 w_oob_transp;
    logic [7:0]           w_chr_color;
    logic                 w_chr_opaque;
    logic                 w_chr_prio;
    logic                 w_unused;

    assign w_sx  = 29'(prod_ax) + 29'(prod_by) + (29'(m7_xorig) <<< 8);
    assign w_sy  = 29'(prod_cx) + 29'(prod_dy) + (29'(m7_yorig) <<< 8);
    assign w_vx  = w_sx[28:8];
    assign w_vy  = w_sy[28:8];
    assign w_oob = (|w_vx[20:10]) | (|w_vy[20:10]);

    // Mode 11 replaces the tile number for out-of-range coordinates; mode 10 blanks the pixel.
    assign w_tile       = (over_q == 2'b11 && oob_q) ? 8'h00 : vram_rdata_l;
    assign w_oob_transp = (over_q == 2'b10) && oob_q;

    always_comb begin
        w_chr_color  = 8'h00;
        w_chr_opaque = 1'b0;
        w_chr_prio   = 1'b0;
`ifdef BG7_EXTBG_EN
        w_chr_color  = {1'b0, vram_rdata_h[6:0]};
        w_chr_prio   = vram_rdata_h[7];
        w_chr_opaque = (vram_rdata_h[6:0] != C_TRANSP[6:0]);
`else
        w_chr_color  = vram_rdata_h;
        w_chr_prio   = 1'b0;
        w_chr_opaque = (vram_rdata_h != C_TRANSP);
`endif
    end

    always_comb begin
        state_d      = state_q;
        vx_d         = vx_q;
        vy_d         = vy_q;
        oob_d        = oob_q;
        over_d       = over_q;
        l_addr_d     = l_addr_q;
        h_addr_d     = h_addr_q;
        stg_color_d  = stg_color_q;
        stg_opaque_d = stg_opaque_q;
        stg_prio_d   = stg_prio_q;
        pix_color_d  = pix_color_q;
        pix_opaque_d = pix_opaque_q;
        pix_prio_d   = pix_prio_q;

        case (state_q)
            S_IDLE: begin
                if (dot_ctr == 3'd2) begin
                    state_d      = S_MAP;
                    vx_d         = w_vx[9:0];
                    vy_d         = w_vy[9:0];
                    oob_d        = w_oob;
                    over_d       = m7sel[3:2];
                    stg_color_d  = 8'h00;
                    stg_opaque_d = 1'b0;
                    stg_prio_d   = 1'b0;
                end
            end
            S_MAP: begin
                if (dot_ctr == 3'd3) begin
                    state_d  = S_CHR;
                    l_addr_d = VRAM_AW'({1'b0, vy_q[9:3], vx_q[9:3]});
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CHR: begin
                if (dot_ctr == 3'd4) begin
                    state_d = S_DONE;
                    if (!w_oob_transp) begin
                        h_addr_d = VRAM_AW'({1'b0, w_tile, vy_q[2:0], vx_q[2:0]});
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                if (dot_ctr == 3'd5 && !w_oob_transp) begin
                    stg_color_d  = w_chr_color;
                    stg_opaque_d = w_chr_opaque;
                    stg_prio_d   = w_chr_prio;
                end
            end
        endcase

        // An aborted fetch leaves nothing valid to show (staging was cleared at start).
        if (dot_en) begin
            pix_color_d  = active ? stg_color_d  : 8'h00;
            pix_opaque_d = active ? stg_opaque_d : 1'b0;
            pix_prio_d   = active ? stg_prio_d   : 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            vx_q         <= '0;
            vy_q         <= '0;
            oob_q        <= 1'b0;
            over_q       <= 2'b00;
            l_addr_q     <= '0;
            h_addr_q     <= '0;
            stg_color_q  <= 8'h00;
            stg_opaque_q <= 1'b0;
            stg_prio_q   <= 1'b0;
            pix_color_q  <= 8'h00;
            pix_opaque_q <= 1'b0;
            pix_prio_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            vx_q         <= vx_d;
            vy_q         <= vy_d;
            oob_q        <= oob_d;
            over_q       <= over_d;
            l_addr_q     <= l_addr_d;
            h_addr_q     <= h_addr_d;
            stg_color_q  <= stg_color_d;
            stg_opaque_q <= stg_opaque_d;
            stg_prio_q   <= stg_prio_d;
            pix_color_q  <= pix_color_d;
            pix_opaque_q <= pix_opaque_d;
            pix_prio_q   <= pix_prio_d;
        end
    end

    assign vram_l_addr  = l_addr_q;
    assign vram_h_addr  = h_addr_q;
    assign pixel_color  = pix_color_q;
    assign pixel_opaque = pix_opaque_q;
    assign pixel_prio   = pix_prio_q;
    assign fetch_busy   = (state_q != S_IDLE);

    assign w_unused = ^{m7sel[1:0], w_sx[7:0], w_sy[7:0]};

endmodule
`default_nettype wire

// File: tb/tb_bg7_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bg7_fetch
//  Purpose  : Self-checking bench for bg7_fetch (vector table + scoreboard).
//  Revision : 1.0  initial release
// ============================================================================
module tb_bg7_fetch;

    logic               clk = 1'b0;
    logic               reset;
    logic               dot_en;
    logic [2:0]         dot_ctr;
    logic               active;
    logic [3:0]         m7sel;
    logic signed [27:0] prod_ax, prod_by, prod_cx, prod_dy;
    logic signed [12:0] m7_xorig, m7_yorig;
    logic [14:0]        vram_l_addr, vram_h_addr;
    logic [7:0]         vram_rdata_l, vram_rdata_h;
    logic [7:0]         pixel_color;
    logic               pixel_opaque, pixel_prio, fetch_busy;

    always #5 clk = ~clk;

    bg7_fetch #(.VRAM_AW(15), .TRANSP_IX(0)) dut (
        .clk(clk), .reset(reset), .dot_en(dot_en), .dot_ctr(dot_ctr),
        .active(active), .m7sel(m7sel),
        .prod_ax(prod_ax), .prod_by(prod_by), .prod_cx(prod_cx), .prod_dy(prod_dy),
        .m7_xorig(m7_xorig), .m7_yorig(m7_yorig),
        .vram_l_addr(vram_l_addr), .vram_h_addr(vram_h_addr),
        .vram_rdata_l(vram_rdata_l), .vram_rdata_h(vram_rdata_h),
        .pixel_color(pixel_color), .pixel_opaque(pixel_opaque),
        .pixel_prio(pixel_prio), .fetch_busy(fetch_busy)
    );

    typedef struct {
        logic signed [27:0] ax, by, cx, dy;
        logic signed [12:0] xo, yo;
        logic [3:0]         sel;
        logic               act;
        logic [7:0]         rl, rh;
        logic [14:0]        el, eh;
        logic               tr;
    } vec_t;

    typedef struct {
        logic [7:0] col;
        logic       op;
        logic       pr;
    } pix_t;

    pix_t sb[$];
    vec_t vt[11];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic pix_t exp_pix(input logic [7:0] raw, input logic tr);
        pix_t p;
        p.col = 8'h00; p.op = 1'b0; p.pr = 1'b0;
        if (!tr) begin
`ifdef BG7_EXTBG_EN
            p.col = {1'b0, raw[6:0]};
            p.pr  = raw[7];
            p.op  = (raw[6:0] != 7'd0);
`else
            p.col = raw;
            p.pr  = 1'b0;
            p.op  = (raw != 8'd0);
`endif
        end
        return p;
    endfunction

    function automatic vec_t mk(input logic signed [27:0] ax, by, cx, dy,
                                input logic signed [12:0] xo, yo,
                                input logic [3:0] sel, input logic act,
                                input logic [7:0] rl, rh,
                                input logic [14:0] el, eh, input logic tr);
        vec_t v;
        v.ax = ax; v.by = by; v.cx = cx; v.dy = dy; v.xo = xo; v.yo = yo;
        v.sel = sel; v.act = act; v.rl = rl; v.rh = rh; v.el = el; v.eh = eh; v.tr = tr;
        return v;
    endfunction

    task automatic step(input logic [2:0] c, input logic en);
        dot_ctr = c;
        dot_en  = en;
        @(posedge clk);
        #1;
        dot_en  = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        prod_ax = v.ax; prod_by = v.by; prod_cx = v.cx; prod_dy = v.dy;
        m7_xorig = v.xo; m7_yorig = v.yo; m7sel = v.sel; active = v.act;
        vram_rdata_l = v.rl; vram_rdata_h = v.rh;
    endtask

    task automatic commit_check(input string nm);
        pix_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: commit with empty scoreboard, got color 0x%0h", nm, pixel_color);
        end else begin
            e = sb.pop_front();
            chk({nm, ".color"},  int'(pixel_color),  int'(e.col));
            chk({nm, ".opaque"}, int'(pixel_opaque), int'(e.op));
            chk({nm, ".prio"},   int'(pixel_prio),   int'(e.pr));
        end
    endtask

    task automatic run_dot(input vec_t v, input string nm);
        apply(v);
        sb.push_back(exp_pix(v.rh, v.tr));
        step(3'd0, 1'b0);
        step(3'd1, 1'b0);
        step(3'd2, 1'b0);
        chk({nm, ".busy_on"}, int'(fetch_busy), 1);
        step(3'd3, 1'b0);
        chk({nm, ".l_addr"}, int'(vram_l_addr), int'(v.el));
        step(3'd4, 1'b0);
        chk({nm, ".h_addr"}, int'(vram_h_addr), int'(v.eh));
        step(3'd5, 1'b0);
        chk({nm, ".busy_off"}, int'(fetch_busy), 0);
        step(3'd6, 1'b0);
        step(3'd7, 1'b1);
        commit_check(nm);
    endtask

    initial begin
        vec_t v;

        vt[0]  = mk(28'sh1500,   0,         0,          28'shB00,   0,    0,  4'h0, 1, 8'h12, 8'h5A, 15'h0082, 15'h049D, 0);
        vt[1]  = mk(-28'sh100,   0,         0,          0,          0,    0,  4'h8, 1, 8'h33, 8'h44, 15'h007F, 15'h049D, 1);
        vt[2]  = mk(-28'sh100,   0,         0,          28'shB00,   0,    0,  4'hC, 1, 8'h77, 8'h5A, 15'h00FF, 15'h001F, 0);
        vt[3]  = mk(28'sh41500,  0,         0,          28'shB00,   0,    0,  4'h7, 1, 8'h12, 8'h5A, 15'h0082, 15'h049D, 0);
        vt[4]  = mk(28'sh1500,   0,         0,          28'shB00,   0,    0,  4'h0, 1, 8'h12, 8'hC5, 15'h0082, 15'h049D, 0);
        vt[5]  = mk(28'sh1500,   0,         0,          28'shB00,   0,    0,  4'h0, 1, 8'h12, 8'h00, 15'h0082, 15'h049D, 0);
        vt[6]  = mk(28'sh1500,   0,         0,          28'shB00,   0,    0,  4'h0, 0, 8'h12, 8'h5A, 15'h0082, 15'h049D, 1);
        vt[7]  = mk(0,           0,         0,          0,          100,  200, 4'h3, 1, 8'hAB, 8'h07, 15'h0C8C, 15'h2AC4, 0);
        vt[8]  = mk(28'sh800,    28'sh300,  28'sh1000,  -28'sh200,  -3,   2,  4'h0, 1, 8'h01, 8'hFF, 15'h0101, 15'h0040, 0);
        vt[9]  = mk(28'sh1500,   0,         0,          28'sh40000, 0,    0,  4'h8, 1, 8'h12, 8'h5A, 15'h0002, 15'h0040, 1);
        vt[10] = mk(28'sh1500,   0,         0,          28'shB00,   0,    0,  4'hC, 1, 8'h12, 8'h5A, 15'h0082, 15'h049D, 0);

        reset = 1'b1; dot_en = 1'b0; dot_ctr = 3'd0;
        apply(vt[0]);
        repeat (2) @(posedge clk);
        #1;
        chk("reset.color",  int'(pixel_color),  0);
        chk("reset.opaque", int'(pixel_opaque), 0);
        chk("reset.l_addr", int'(vram_l_addr),  0);
        chk("reset.h_addr", int'(vram_h_addr),  0);
        chk("reset.busy",   int'(fetch_busy),   0);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            run_dot(vt[i], $sformatf("vec%0d", i));
        end

        // dot_en on the DONE cycle takes the freshly captured colour
        v = vt[0];
        v.rh = 8'h3C;
        apply(v);
        sb.push_back(exp_pix(8'h3C, 1'b0));
        step(3'd0, 1'b0); step(3'd1, 1'b0); step(3'd2, 1'b0);
        step(3'd3, 1'b0); step(3'd4, 1'b0); step(3'd5, 1'b1);
        commit_check("done_commit");
        step(3'd6, 1'b0); step(3'd7, 1'b0);

        // commit before the fetch finishes is transparent
        apply(vt[0]);
        sb.push_back(exp_pix(8'h00, 1'b1));
        step(3'd0, 1'b0); step(3'd1, 1'b0); step(3'd2, 1'b0);
        step(3'd3, 1'b1);
        commit_check("early_commit");
        sb.push_back(exp_pix(8'h5A, 1'b0));
        step(3'd4, 1'b0); step(3'd5, 1'b0); step(3'd6, 1'b0);
        step(3'd7, 1'b1);
        commit_check("late_commit");

        // phase slip in DONE aborts the fetch
        apply(vt[0]);
        sb.push_back(exp_pix(8'h00, 1'b1));
        step(3'd0, 1'b0); step(3'd1, 1'b0); step(3'd2, 1'b0);
        step(3'd3, 1'b0); step(3'd4, 1'b0); step(3'd4, 1'b0);
        chk("abort.busy", int'(fetch_busy), 0);
        step(3'd6, 1'b0);
        step(3'd7, 1'b1);
        commit_check("abort");

        // asynchronous reset while in CHR
        run_dot(vt[0], "pre_reset");
        step(3'd0, 1'b0); step(3'd1, 1'b0); step(3'd2, 1'b0); step(3'd3, 1'b0);
        dot_ctr = 3'd4;
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst.color",  int'(pixel_color),  0);
        chk("async_rst.opaque", int'(pixel_opaque), 0);
        chk("async_rst.l_addr", int'(vram_l_addr),  0);
        chk("async_rst.h_addr", int'(vram_h_addr),  0);
        chk("async_rst.busy",   int'(fetch_busy),   0);
        @(posedge clk);
        #1;
        step(3'd5, 1'b0);
        reset = 1'b0;
        step(3'd6, 1'b0);
        sb.push_back(exp_pix(8'h00, 1'b1));
        step(3'd7, 1'b1);
        commit_check("post_reset");

        chk("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
